// File: rtl/sm_regdump.sv
// sm_regdump: walks registers FIRST_REG..LAST_REG and streams each one out as a 5-byte UART 8N1 frame.
// Latency: the first start bit leaves SETTLE+2 cycles after start is accepted; each register takes SETTLE+2+50*BAUD_DIV cycles.
// Backpressure: none; start is dropped while busy and on the done cycle, and requests are not queued.
module sm_regdump #(
  parameter int BAUD_DIV  = 434,
  parameter int SETTLE    = 2,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic        tx
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_START_BIT,
    ST_DATA_BITS,
    ST_STOP_BIT,
    ST_NEXT
  } state_t;

  localparam logic [15:0] BAUD_LAST   = 16'(BAUD_DIV - 1);
  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [4:0]  FIRST_ADDR  = 5'(FIRST_REG);
  localparam logic [4:0]  LAST_ADDR   = 5'(LAST_REG);

  state_t      state, next_state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [2:0]  byte_idx;
  logic [3:0]  settle_cnt;
  logic [31:0] shadow;
  logic [7:0]  cur_byte;
  logic        baud_tc;
  logic        accept;
  logic        last_reg;

  // A start that lands on the done cycle is dropped along with those seen while busy.
  assign accept   = (state == ST_IDLE) && start && !done;
  assign baud_tc  = (baud_cnt == BAUD_LAST);
  assign last_reg = (regAddr == LAST_ADDR);

  // Frame byte 0 is the register index (regAddr holds still for the whole frame), bytes 1..4 the captured word MSB first.
  always_comb begin
    cur_byte = {3'b000, regAddr};
    case (byte_idx)
      3'd1:    cur_byte = shadow[31:24];
      3'd2:    cur_byte = shadow[23:16];
      3'd3:    cur_byte = shadow[15:8];
      3'd4:    cur_byte = shadow[7:0];
      default: cur_byte = {3'b000, regAddr};
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state logic: settle, capture, five back-to-back bytes, then advance or finish.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:      if (accept) next_state = ST_SETTLE;
      ST_SETTLE:    if (settle_cnt == SETTLE_LAST) next_state = ST_CAPTURE;
      ST_CAPTURE:   next_state = ST_START_BIT;
      ST_START_BIT: if (baud_tc) next_state = ST_DATA_BITS;
      ST_DATA_BITS: if (baud_tc && bit_cnt == 3'd7) next_state = ST_STOP_BIT;
      ST_STOP_BIT:  if (baud_tc) next_state = (byte_idx == 3'd4) ? ST_NEXT : ST_START_BIT;
      ST_NEXT:      next_state = last_reg ? ST_IDLE : ST_SETTLE;
      default:      next_state = ST_IDLE;
    endcase
  end

  // Counters, shadow capture, handshake flags and the registered serial output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      byte_idx   <= '0;
      settle_cnt <= '0;
      shadow     <= '0;
      regAddr    <= FIRST_ADDR;
      busy       <= 1'b0;
      done       <= 1'b0;
      tx         <= 1'b1;
    end else begin
      done <= 1'b0;

      if (state == ST_START_BIT || state == ST_DATA_BITS || state == ST_STOP_BIT)
        baud_cnt <= baud_tc ? 16'd0 : baud_cnt + 16'd1;
      else
        baud_cnt <= '0;

      if (state != ST_DATA_BITS) bit_cnt <= '0;
      else if (baud_tc)          bit_cnt <= bit_cnt + 3'd1;

      if (state == ST_SETTLE) settle_cnt <= settle_cnt + 4'd1;
      else                    settle_cnt <= '0;

      if (state == ST_CAPTURE) begin
        shadow   <= regData;
        byte_idx <= '0;
      end else if (state == ST_STOP_BIT && baud_tc) begin
        byte_idx <= byte_idx + 3'd1;
      end

      if (accept) begin
        regAddr <= FIRST_ADDR;
        busy    <= 1'b1;
      end else if (state == ST_NEXT) begin
        if (last_reg) begin
          regAddr <= FIRST_ADDR;
          busy    <= 1'b0;
          done    <= 1'b1;
        end else begin
          regAddr <= regAddr + 5'd1;
        end
      end

      case (state)
        ST_START_BIT: tx <= 1'b0;
        ST_DATA_BITS: tx <= cur_byte[bit_cnt];
        default:      tx <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_regdump.sv
// tb_sm_regdump: drives two sm_regdump instances (full 0..31 walk at 4 clk/bit, single register 3 at 2 clk/bit).
// Latency: outputs are compared each negedge against a cycle-offset model of the frame timing.
// Backpressure: n/a; start pulses are also issued while busy and on the done cycle.
module tb_sm_regdump;

  localparam int BD [2] = '{4, 2};
  localparam int SD [2] = '{2, 1};
  localparam int FR [2] = '{0, 3};
  localparam int LR [2] = '{31, 3};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_s [2];
  logic        busy_s  [2];
  logic        done_s  [2];
  logic        tx_s    [2];
  logic [4:0]  ra      [2];
  logic [31:0] rd      [2];
  logic [31:0] regs0   [32];
  logic [31:0] regs1   [32];

  int nvec = 0;
  int errs = 0;

  // model state
  bit          mact  [2];
  bit          mdone [2];
  int          mt    [2];
  logic [31:0] snap  [2][32];

  // bench-side observers
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         dn [2];

  always #5 clk = ~clk;

  assign rd[0] = regs0[ra[0]];
  assign rd[1] = regs1[ra[1]];

  sm_regdump #(.BAUD_DIV(4), .SETTLE(2), .FIRST_REG(0), .LAST_REG(31)) u0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .regAddr(ra[0]), .regData(rd[0]), .tx(tx_s[0]));

  sm_regdump #(.BAUD_DIV(2), .SETTLE(1), .FIRST_REG(3), .LAST_REG(3)) u1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .regAddr(ra[1]), .regData(rd[1]), .tx(tx_s[1]));

  function automatic int per_reg(int i);
    return SD[i] + 2 + 50 * BD[i];
  endfunction

  function automatic int nregs(int i);
    return LR[i] - FR[i] + 1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: counts edges since the accepting edge; start is taken only when idle and not on the done cycle.
  initial begin : model_p
    forever begin
      @(posedge clk or posedge rst);
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          mact[i] = 0; mdone[i] = 0; mt[i] = 0;
        end else if (mact[i]) begin
          mt[i]++;
          if (mt[i] == nregs(i) * per_reg(i)) begin
            mact[i] = 0; mdone[i] = 1;
          end
        end else if (mdone[i]) begin
          mdone[i] = 0;
        end else if (start_s[i]) begin
          mact[i] = 1; mt[i] = 0;
          for (int j = 0; j < 32; j++) snap[i][j] = (i == 0) ? regs0[j] : regs1[j];
        end
      end
    end
  end

  // Per-cycle compare of {tx, busy, done, regAddr} against the model.
  initial begin : cmp_p
    int t, r, o, bp, by, bt, addr;
    logic [31:0] w;
    logic [7:0]  bv, e, a;
    logic        etx;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int i = 0; i < 2; i++) begin
          if (mact[i]) begin
            t = mt[i]; r = t / per_reg(i); o = t % per_reg(i); addr = FR[i] + r;
            etx = 1'b1;
            if (o >= SD[i] + 2) begin
              bp = (o - SD[i] - 2) / BD[i]; by = bp / 10; bt = bp % 10;
              if (by == 0) bv = 8'(addr);
              else begin
                w  = snap[i][addr] >> (8 * (4 - by));
                bv = w[7:0];
              end
              if (bt == 0)      etx = 1'b0;
              else if (bt == 9) etx = 1'b1;
              else              etx = bv[bt-1];
            end
            e = {etx, 1'b1, 1'b0, 5'(addr)};
          end else begin
            e = {1'b1, 1'b0, mdone[i], 5'(FR[i])};
          end
          a = {tx_s[i], busy_s[i], done_s[i], ra[i]};
          chk(i == 0 ? "u0 tx/busy/done/regAddr" : "u1 tx/busy/done/regAddr", 64'(a), 64'(e));
        end
      end
    end
  end

  // UART receiver: samples mid-bit and collects whole bytes; also counts done pulses.
  initial begin : rx_p
    bit         dact [2];
    int         dc   [2];
    logic [7:0] dsh  [2];
    int         j;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (done_s[i] === 1'b1) dn[i]++;
        if (rst) dact[i] = 0;
        else if (!dact[i]) begin
          if (tx_s[i] == 1'b0) begin dact[i] = 1; dc[i] = 0; end
        end else begin
          dc[i]++;
          if (dc[i] % BD[i] == BD[i] / 2) begin
            j = dc[i] / BD[i];
            if (j >= 1 && j <= 8) dsh[i][j-1] = tx_s[i];
            if (j == 9) begin
              if (i == 0) q0.push_back(dsh[i]); else q1.push_back(dsh[i]);
              dact[i] = 0;
            end
          end
        end
      end
    end
  end

  task automatic pulse(input int i);
    @(negedge clk);
    start_s[i] = 1'b1;
    @(negedge clk);
    start_s[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i, input int lim, output int n);
    n = 0;
    while (busy_s[i] && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("busy falls within budget", 64'(busy_s[i]), 64'd0);
  endtask

  initial begin : stim_p
    int n, d0;
    logic [7:0]  exp1 [5];
    logic [31:0] word;
    exp1 = '{8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    start_s[0] = 1'b0; start_s[1] = 1'b0;
    dn[0] = 0; dn[1] = 0;
    for (int j = 0; j < 32; j++) begin
      regs0[j] = 32'h1000 + 32'(j);
      regs1[j] = 32'h0;
    end
    regs1[3] = 32'hDEADBEEF;

    // reset values
    repeat (2) @(negedge clk);
    chk("u0 reset {tx,busy,done,addr}", 64'({tx_s[0], busy_s[0], done_s[0], ra[0]}), 64'({1'b1, 1'b0, 1'b0, 5'd0}));
    chk("u1 reset {tx,busy,done,addr}", 64'({tx_s[1], busy_s[1], done_s[1], ra[1]}), 64'({1'b1, 1'b0, 1'b0, 5'd3}));
    rst = 1'b0;
    @(negedge clk);

    // single register 3 = DEADBEEF at 2 clk/bit, SETTLE 1
    q1.delete(); dn[1] = 0;
    pulse(1);
    wait_idle(1, 500, n);
    chk("u1 busy length", 64'(n), 64'd103);
    chk("u1 done on busy fall", 64'(done_s[1]), 64'd1);
    repeat (3) @(negedge clk);
    chk("u1 byte count", 64'(q1.size()), 64'd5);
    for (int b = 0; b < 5; b++) chk("u1 frame byte", 64'(q1[b]), 64'(exp1[b]));
    chk("u1 done count", 64'(dn[1]), 64'd1);
    chk("u1 regAddr after", 64'(ra[1]), 64'd3);

    // full walk 0..31; regs0[5] rewritten one cycle after its capture; starts while busy
    q0.delete(); dn[0] = 0;
    pulse(0);
    repeat (1024) @(negedge clk);
    regs0[5] = 32'h12345678;
    for (int p = 0; p < 4; p++) begin
      repeat (1000) @(negedge clk);
      start_s[0] = 1'b1;
      @(negedge clk);
      start_s[0] = 1'b0;
    end
    wait_idle(0, 8000, n);
    chk("u0 done on busy fall", 64'(done_s[0]), 64'd1);
    chk("u0 byte count", 64'(q0.size()), 64'd160);
    for (int f = 0; f < 32; f++) chk("u0 frame address byte", 64'(q0[5*f]), 64'(f));
    word = {q0[26], q0[27], q0[28], q0[29]};
    chk("u0 frame 5 data held at capture", 64'(word), 64'h1005);
    word = {q0[156], q0[157], q0[158], q0[159]};
    chk("u0 frame 31 data", 64'(word), 64'h101F);
    chk("u0 regAddr after walk", 64'(ra[0]), 64'd0);
    // start during the done cycle is dropped
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    chk("u0 no restart from done cycle", 64'(busy_s[0]), 64'd0);
    chk("u0 done pulse count", 64'(dn[0]), 64'd1);
    // start one cycle later is taken
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    chk("u0 restart accepted", 64'(busy_s[0]), 64'd1);

    // reset inside data bit 3 of byte 2 (tx is 0 there)
    repeat (100) @(posedge clk);
    #1;
    chk("u0 tx before reset", 64'(tx_s[0]), 64'd0);
    d0 = dn[0];
    rst = 1'b1;
    #1;
    chk("u0 async reset {tx,busy,addr}", 64'({tx_s[0], busy_s[0], ra[0]}), 64'({1'b1, 1'b0, 5'd0}));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("u0 no done after reset", 64'(dn[0]), 64'(d0));

    // clean walk after reset
    q0.delete(); dn[0] = 0;
    pulse(0);
    wait_idle(0, 8000, n);
    chk("u0 busy length", 64'(n), 64'd6528);
    repeat (3) @(negedge clk);
    chk("u0 byte count after reset", 64'(q0.size()), 64'd160);
    for (int f = 0; f < 32; f++) chk("u0 frame address byte", 64'(q0[5*f]), 64'(f));
    word = {q0[26], q0[27], q0[28], q0[29]};
    chk("u0 frame 5 new data", 64'(word), 64'h12345678);
    chk("u0 done count after reset", 64'(dn[0]), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule
